// File: rtl/gates_tt_checker_if.sv
// Bundles the checker's control handshake and the gate-block stimulus/response signals.
// The checker (slave) drives the operands and status; the environment (master) drives the rest.
interface gates_tt_checker_if;
    logic       start;
    logic       a;
    logic       b;
    logic       c_and;
    logic       c_or;
    logic       c_not;
    logic       c_xor;
    logic       c_xnor;
    logic       c_nand;
    logic       c_nor;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] fail_mask;

    modport slave (
        input  start,
        input  c_and,
        input  c_or,
        input  c_not,
        input  c_xor,
        input  c_xnor,
        input  c_nand,
        input  c_nor,
        output a,
        output b,
        output busy,
        output done,
        output pass,
        output fail_mask
    );

    modport master (
        output start,
        output c_and,
        output c_or,
        output c_not,
        output c_xor,
        output c_xnor,
        output c_nand,
        output c_nor,
        input  a,
        input  b,
        input  busy,
        input  done,
        input  pass,
        input  fail_mask
    );
endinterface

// File: rtl/gates_tt_checker.sv
// Sweeps the four (a,b) vectors through an external gate block and accumulates sticky
// per-gate mismatch flags; reports pass/done once the sweep is complete.
module gates_tt_checker #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    gates_tt_checker_if.slave  bus
);

    typedef enum logic [2:0] {
        StIdle,
        StApply,
        StWait,
        StSample,
        StFinish
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic [6:0] mask_q, mask_d;
    logic       pass_q, pass_d;

    logic [6:0] expected;
    logic [6:0] observed;
    logic [6:0] mism;
    logic [6:0] mask_upd;
    logic [1:0] idx_inc;

    // Bit order matches fail_mask: and, or, not, xor, xnor, nand, nor.
    always_comb begin
        expected = {~(a_q | b_q), ~(a_q & b_q), ~(a_q ^ b_q), a_q ^ b_q, ~b_q, a_q | b_q,
                    a_q & b_q};
        observed = {bus.c_nor, bus.c_nand, bus.c_xnor, bus.c_xor, bus.c_not, bus.c_or,
                    bus.c_and};
        mism     = expected ^ observed;
        mask_upd = mask_q | mism;
        idx_inc  = idx_q + 2'd1;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        mask_d  = mask_q;
        pass_d  = pass_q;

        unique case (state_q)
            StIdle: begin
                a_d = 1'b0;
                b_d = 1'b0;
                if (bus.start) begin
                    state_d = StApply;
                    idx_d   = 2'd0;
                    mask_d  = 7'b0000000;
                    pass_d  = 1'b0;
                end
            end
            StApply: begin
                cnt_d   = 4'(SETTLE_CYCLES);
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                mask_d = mask_upd;
                if (idx_q == 2'd3) begin
                    // pass is registered here so it is valid alongside done in FINISH.
                    pass_d  = (mask_upd == 7'b0000000);
                    state_d = StFinish;
                end else begin
                    idx_d   = idx_inc;
                    a_d     = idx_inc[1];
                    b_d     = idx_inc[0];
                    state_d = StApply;
                end
            end
            StFinish: begin
                a_d     = 1'b0;
                b_d     = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            mask_q  <= 7'b0000000;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StFinish);
    assign bus.pass      = pass_q;
    assign bus.fail_mask = mask_q;

endmodule

// File: doc/gates_tt_checker.md
GATES_TT_CHECKER -- requirements
Module: gates_tt_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 1, SHALL set the cycles waited between driving a vector and sampling the gate outputs; the legal range is 1..15.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 start  input  1  SHALL request one truth-table sweep; sampled only in IDLE.
REQ-005 a  output  1  SHALL be the registered operand A driven to the gate block under test.
REQ-006 b  output  1  SHALL be the registered operand B driven to the gate block under test.
REQ-007 c_and, c_or, c_not, c_xor, c_xnor, c_nand, c_nor  input  1 each  SHALL be the gate block's results for the current a,b.
REQ-008 busy  output  1  SHALL be high while a sweep is in progress (any state other than IDLE).
REQ-009 done  output  1  SHALL be a one-cycle pulse marking sweep completion.
REQ-010 pass  output  1  SHALL be high when the last completed sweep found no mismatch.
REQ-011 fail_mask  output  7  SHALL be the per-gate sticky mismatch flags: [0]and [1]or [2]not [3]xor [4]xnor [5]nand [6]nor.

Function
REQ-012 FSM states SHALL be IDLE, APPLY, WAIT, SAMPLE, FINISH, held in a registered state variable.
REQ-013 IDLE SHALL behave as follows:
- a=b=0, busy=0.
- start=1 -> go to APPLY with vector index idx=0, and clear fail_mask to 0 and pass to 0 on the same edge.
REQ-014 APPLY SHALL last 1 cycle:
- a=idx[1], b=idx[0] are registered on entry.
- Settle counter is loaded with SETTLE_CYCLES.
- Next state is WAIT.
REQ-015 WAIT SHALL last exactly SETTLE_CYCLES cycles, with a and b held stable, then go to SAMPLE.
REQ-016 SAMPLE SHALL last 1 cycle and perform the check:
- Compare each input with its expected value: and=a&b, or=a|b, not=~b, xor=a^b, xnor=~(a^b), nand=~(a&b), nor=~(a|b).
- OR each mismatch into the corresponding fail_mask bit.
REQ-017 SAMPLE exit SHALL depend on idx:
- idx!=3 -> increment idx (2-bit) and go to APPLY.
- idx==3 -> go to FINISH; idx SHALL NOT wrap to a fifth vector.
REQ-018 Vector order SHALL be (a,b) = 00, 01, 10, 11.
REQ-019 FINISH SHALL last 1 cycle:
- done=1.
- pass = (final fail_mask==0), registered so it is valid in the same cycle as done.
- Next state is IDLE.
REQ-020 pass and fail_mask SHALL hold their values after FINISH until the next accepted start or rst.
REQ-021 Latency: with start sampled high in IDLE at cycle 0, done SHALL be high in cycle 4*(SETTLE_CYCLES+2)+1; for SETTLE_CYCLES=1 that is cycle 13.
REQ-022 start SHALL be ignored while busy=1 and during FINISH; no restart and no mask clear.
REQ-023 start held high continuously SHALL begin a new sweep on the first IDLE cycle after FINISH.
REQ-024 Sampled inputs that are X/Z are out of scope; only 0/1 values are compared.

Reset
REQ-025 rst=1 at any rising edge SHALL force the following on the next cycle, overriding start and any in-progress state:
- state=IDLE, idx=0, settle counter=0.
- a=0, b=0.
- busy=0, done=0, pass=0, fail_mask=7'b0000000.
REQ-026 rst asserted mid-sweep SHALL abort the sweep; done SHALL NOT pulse for the aborted sweep.

Verification
REQ-027 Golden gate block connected, SETTLE_CYCLES=1, start pulsed at cycle 0 -> a,b step through 00,01,10,11; done=1 at cycle 13 only; pass=1; fail_mask=7'b0000000.
REQ-028 c_and forced to 0 -> after sweep: fail_mask=7'b0000001, pass=0 (mismatch at vector 11 only).
REQ-029 c_xor inverted and c_nor forced to 1 -> fail_mask=7'b1001000, pass=0.
REQ-030 Start while busy and restart:
- start re-pulsed at cycle 5 -> ignored; done still at cycle 13.
- Second start after done, golden block -> fail_mask cleared at acceptance; pass=1 at the second done.
REQ-031 rst asserted at cycle 7 mid-sweep -> cycle 8: busy=0, a=b=0, fail_mask=0, pass=0; no done pulse before a new start.
REQ-032 SETTLE_CYCLES=3, golden block -> each vector held 5 cycles; done=1 at cycle 21; pass=1.
